morse_receiver: RTL and testbench



---
 rtl/morse_receiver.sv | 165 ++++++++++++++++
 tb/tb_morse_receiver.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_receiver.sv
// Morse line receiver: measures mark/space run lengths, assembles ITU symbols and strobes ASCII out.
// Optional MORSE_RX_ERR_EN adds o_err (pulsed with '?') and a saturating error counter o_err_cnt.
module morse_receiver #(
    parameter int UNIT_CYCLES = 1,
    parameter int CNT_W       = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_data_morse,
    output logic [7:0] o_char,
    output logic       o_valid,
    output logic       o_busy
`ifdef MORSE_RX_ERR_EN
    ,
    output logic       o_err,
    output logic [7:0] o_err_cnt
`endif
);

    localparam logic [CNT_W-1:0] DASH_MIN   = CNT_W'(2 * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] LETTER_GAP = CNT_W'(3 * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] WORD_GAP   = CNT_W'(6 * UNIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        MARK,
        SPACE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] run;
    logic [CNT_W-1:0] run_inc;
    logic [4:0]       pattern;
    logic [2:0]       len;
    logic             overflow;
    logic             word_pending;
    logic [7:0]       decoded;
    logic [7:0]       letter;

    // Elements are shifted in MSB-first (dot=0, dash=1); unused upper bits stay zero.
    function automatic logic [7:0] decode(input logic [2:0] n, input logic [4:0] p);
        logic [7:0] c;
        case ({n, p})
            {3'd1, 5'b00000}: c = 8'h45; // E
            {3'd1, 5'b00001}: c = 8'h54; // T
            {3'd2, 5'b00000}: c = 8'h49; // I
            {3'd2, 5'b00001}: c = 8'h41; // A
            {3'd2, 5'b00010}: c = 8'h4E; // N
            {3'd2, 5'b00011}: c = 8'h4D; // M
            {3'd3, 5'b00000}: c = 8'h53; // S
            {3'd3, 5'b00001}: c = 8'h55; // U
            {3'd3, 5'b00010}: c = 8'h52; // R
            {3'd3, 5'b00011}: c = 8'h57; // W
            {3'd3, 5'b00100}: c = 8'h44; // D
            {3'd3, 5'b00101}: c = 8'h4B; // K
            {3'd3, 5'b00110}: c = 8'h47; // G
            {3'd3, 5'b00111}: c = 8'h4F; // O
            {3'd4, 5'b00000}: c = 8'h48; // H
            {3'd4, 5'b00001}: c = 8'h56; // V
            {3'd4, 5'b00010}: c = 8'h46; // F
            {3'd4, 5'b00100}: c = 8'h4C; // L
            {3'd4, 5'b00110}: c = 8'h50; // P
            {3'd4, 5'b00111}: c = 8'h4A; // J
            {3'd4, 5'b01000}: c = 8'h42; // B
            {3'd4, 5'b01001}: c = 8'h58; // X
            {3'd4, 5'b01010}: c = 8'h43; // C
            {3'd4, 5'b01011}: c = 8'h59; // Y
            {3'd4, 5'b01100}: c = 8'h5A; // Z
            {3'd4, 5'b01101}: c = 8'h51; // Q
            {3'd5, 5'b00000}: c = 8'h35; // 5
            {3'd5, 5'b00001}: c = 8'h34; // 4
            {3'd5, 5'b00011}: c = 8'h33; // 3
            {3'd5, 5'b00111}: c = 8'h32; // 2
            {3'd5, 5'b01111}: c = 8'h31; // 1
            {3'd5, 5'b10000}: c = 8'h36; // 6
            {3'd5, 5'b11000}: c = 8'h37; // 7
            {3'd5, 5'b11100}: c = 8'h38; // 8
            {3'd5, 5'b11110}: c = 8'h39; // 9
            {3'd5, 5'b11111}: c = 8'h30; // 0
            default:          c = 8'h3F; // ?
        endcase
        return c;
    endfunction

    assign run_inc = (&run) ? run : run + 1'b1;
    assign decoded = decode(len, pattern);
    assign letter  = overflow ? 8'h3F : decoded;
    assign o_busy  = (state != IDLE);

    // The 0 that ends a mark is already the first gap unit, so SPACE starts with run=1.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= IDLE;
            run          <= '0;
            pattern      <= '0;
            len          <= '0;
            overflow     <= 1'b0;
            word_pending <= 1'b0;
            o_char       <= 8'h00;
            o_valid      <= 1'b0;
`ifdef MORSE_RX_ERR_EN
            o_err        <= 1'b0;
            o_err_cnt    <= 8'h00;
`endif
        end else begin
            o_valid <= 1'b0;
`ifdef MORSE_RX_ERR_EN
            o_err   <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (i_data_morse) begin
                        state <= MARK;
                        run   <= CNT_W'(1);
                    end
                end
                MARK: begin
                    if (i_data_morse) begin
                        run <= run_inc;
                    end else begin
                        if (len == 3'd5) begin
                            overflow <= 1'b1;
                        end else begin
                            pattern <= {pattern[3:0], (run >= DASH_MIN)};
                            len     <= len + 3'd1;
                        end
                        state <= SPACE;
                        run   <= CNT_W'(1);
                    end
                end
                SPACE: begin
                    if (i_data_morse) begin
                        state        <= MARK;
                        run          <= CNT_W'(1);
                        word_pending <= 1'b0;
                    end else begin
                        run <= run_inc;
                        if (run_inc == LETTER_GAP && len != 3'd0) begin
                            o_char       <= letter;
                            o_valid      <= 1'b1;
                            pattern      <= '0;
                            len          <= '0;
                            overflow     <= 1'b0;
                            word_pending <= 1'b1;
`ifdef MORSE_RX_ERR_EN
                            if (letter == 8'h3F) begin
                                o_err <= 1'b1;
                                if (o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 8'd1;
                            end
`endif
                        end else if (run_inc == WORD_GAP && word_pending) begin
                            o_char       <= 8'h20;
                            o_valid      <= 1'b1;
                            word_pending <= 1'b0;
                            state        <= IDLE;
                            run          <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_morse_receiver.sv
// Scoreboard bench for morse_receiver: one instance at UNIT_CYCLES=1 and one at UNIT_CYCLES=4,
// driven with directed and random Morse text; expected characters come from an ITU code table.
module tb_morse_receiver;

    typedef struct {
        logic [7:0] ch;
        int         at;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       line0 = 1'b0;
    logic       line1 = 1'b0;
    logic [7:0] char0, char1;
    logic       valid0, valid1, busy0, busy1;
`ifdef MORSE_RX_ERR_EN
    logic       err0, err1;
    logic [7:0] ecnt0, ecnt1;
`endif

    int   total = 0;
    int   bad = 0;
    int   idx = 0;
    int   exp_err0 = 0;
    int   exp_err1 = 0;
    exp_t q0[$];
    exp_t q1[$];

    string codes[36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
                         "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
                         "..-", "...-", ".--", "-..-", "-.--", "--..",
                         "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...",
                         "---..", "----."};
    string alphabet = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789";

    always #5 clk = ~clk;

    morse_receiver #(.UNIT_CYCLES(1), .CNT_W(8)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_data_morse(line0),
        .o_char(char0), .o_valid(valid0), .o_busy(busy0)
`ifdef MORSE_RX_ERR_EN
        , .o_err(err0), .o_err_cnt(ecnt0)
`endif
    );

    morse_receiver #(.UNIT_CYCLES(4), .CNT_W(8)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_data_morse(line1),
        .o_char(char1), .o_valid(valid1), .o_busy(busy1)
`ifdef MORSE_RX_ERR_EN
        , .o_err(err1), .o_err_cnt(ecnt1)
`endif
    );

    function automatic void check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
        end
    endfunction

    // Reference decoder works on the dot/dash text of a symbol, not on run lengths.
    function automatic logic [7:0] ref_decode(input string code);
        if (code.len() > 5) return 8'h3F;
        for (int k = 0; k < 36; k++)
            if (codes[k] == code) return alphabet[k];
        return 8'h3F;
    endfunction

    function automatic void expect_char(input int which, input logic [7:0] ch, input int at);
        exp_t e;
        e.ch = ch;
        e.at = at;
        if (which == 0) begin
            q0.push_back(e);
            if (ch == 8'h3F && exp_err0 < 255) exp_err0++;
        end else begin
            q1.push_back(e);
            if (ch == 8'h3F && exp_err1 < 255) exp_err1++;
        end
    endfunction

    task automatic applyStimulus(input int which, input logic b);
        @(negedge clk);
        if (which == 0) line0 = b;
        else line1 = b;
        idx++;
    endtask

    task automatic drive_run(input int which, input logic b, input int n);
        repeat (n) applyStimulus(which, b);
    endtask

    task automatic drive_bits(input int which, input string bits);
        for (int i = 0; i < bits.len(); i++) applyStimulus(which, bits[i] == "1");
    endtask

    // Sends one symbol with random element/gap lengths legal for the given unit.
    task automatic send_code(input int which, input int unit, input string code, input bit word);
        int base;
        int gap;
        for (int i = 0; i < code.len(); i++) begin
            if (code[i] == "-") drive_run(which, 1'b1, $urandom_range(4 * unit, 2 * unit));
            else drive_run(which, 1'b1, $urandom_range(2 * unit - 1, 1));
            if (i < code.len() - 1) drive_run(which, 1'b0, $urandom_range(3 * unit - 1, 1));
        end
        base = idx;
        expect_char(which, ref_decode(code), base + 3 * unit);
        if (word) begin
            expect_char(which, 8'h20, base + 6 * unit);
            gap = $urandom_range(6 * unit + 3, 6 * unit);
        end else begin
            gap = $urandom_range(6 * unit - 1, 3 * unit);
        end
        drive_run(which, 1'b0, gap);
    endtask

    task automatic checkOutput(input int which, input logic [7:0] ch, input logic busy);
        exp_t e;
        bit   have;
        have = 1'b0;
        total++;
        if (which == 0) begin
            if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
        end else begin
            if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
        end
        if (!have) begin
            bad++;
            $display("[TB] FAIL strobe_unexpected dut%0d: got char=%h at sample %0d, required no strobe",
                     which, ch, idx);
            return;
        end
        if (ch !== e.ch || idx != e.at) begin
            bad++;
            $display("[TB] FAIL char dut%0d: got %h at sample %0d, required %h at sample %0d",
                     which, ch, idx, e.ch, e.at);
        end
        check_eq($sformatf("busy_at_strobe%0d", which), {31'b0, busy}, {31'b0, (e.ch != 8'h20)});
`ifdef MORSE_RX_ERR_EN
        if (which == 0) check_eq("err0", {31'b0, err0}, {31'b0, (e.ch == 8'h3F)});
        else check_eq("err1", {31'b0, err1}, {31'b0, (e.ch == 8'h3F)});
`endif
    endtask

    // Monitors sample mid-cycle, after the driver has counted the bit the last edge sampled.
    always begin
        @(posedge clk);
        #2;
        if (valid0 === 1'b1) checkOutput(0, char0, busy0);
    end

    always begin
        @(posedge clk);
        #2;
        if (valid1 === 1'b1) checkOutput(1, char1, busy1);
    end

    initial begin
        int    b;
        string code;
        #1 rst = 1'b1;
        #5;
        check_eq("rst_char0", {24'b0, char0}, 32'h00);
        check_eq("rst_valid0", {31'b0, valid0}, 32'h0);
        check_eq("rst_busy0", {31'b0, busy0}, 32'h0);
        check_eq("rst_char1", {24'b0, char1}, 32'h00);
        check_eq("rst_valid1", {31'b0, valid1}, 32'h0);
        check_eq("rst_busy1", {31'b0, busy1}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Unit=1 directed cases
        b = idx;
        expect_char(0, "T", b + 6);
        expect_char(0, 8'h20, b + 9);
        drive_bits(0, "1110000000");
        b = idx;
        expect_char(0, "S", b + 8);
        expect_char(0, 8'h20, b + 11);
        drive_bits(0, "1010100000000");
        b = idx;
        expect_char(0, "9", b + 20);
        expect_char(0, 8'h20, b + 23);
        drive_bits(0, "11101110111011101000000");
        b = idx;
        expect_char(0, "1", b + 20);
        expect_char(0, 8'h20, b + 23);
        drive_bits(0, "10111011101110111000000");
        b = idx;
        expect_char(0, 8'h3F, b + 14);
        expect_char(0, 8'h20, b + 17);
        drive_bits(0, "10101010101000000");
        drive_run(0, 1'b1, 300);
        b = idx;
        expect_char(0, "T", b + 3);
        expect_char(0, 8'h20, b + 6);
        drive_run(0, 1'b0, 7);

        // Asynchronous reset in the middle of a symbol discards it
        drive_bits(0, "101");
        #2 rst = 1'b1;
        line0 = 1'b0;
        #1;
        check_eq("midrst_char0", {24'b0, char0}, 32'h00);
        check_eq("midrst_valid0", {31'b0, valid0}, 32'h0);
        check_eq("midrst_busy0", {31'b0, busy0}, 32'h0);
        #1 rst = 1'b0;
        drive_run(0, 1'b0, 6);
        check_eq("midrst_busy_after0", {31'b0, busy0}, 32'h0);
        check_eq("midrst_char_after0", {24'b0, char0}, 32'h00);

        // Unit=4 directed cases, including the dot/dash boundary
        drive_run(1, 1'b1, 12);
        b = idx;
        expect_char(1, "T", b + 12);
        expect_char(1, 8'h20, b + 24);
        drive_run(1, 1'b0, 26);
        drive_run(1, 1'b1, 4);
        b = idx;
        expect_char(1, "E", b + 12);
        expect_char(1, 8'h20, b + 24);
        drive_run(1, 1'b0, 26);
        drive_run(1, 1'b1, 7);
        b = idx;
        expect_char(1, "E", b + 12);
        expect_char(1, 8'h20, b + 24);
        drive_run(1, 1'b0, 25);
        drive_run(1, 1'b1, 8);
        b = idx;
        expect_char(1, "T", b + 12);
        expect_char(1, 8'h20, b + 24);
        drive_run(1, 1'b0, 25);

        // Random text: mostly valid letters, some arbitrary dot/dash strings up to 6 long
        for (int w = 0; w < 2; w++) begin
            for (int n = 0; n < 40; n++) begin
                if ($urandom_range(4, 0) == 0) begin
                    code = "";
                    for (int e = 0; e < int'($urandom_range(6, 1)); e++)
                        code = {code, ($urandom_range(1, 0) == 1) ? "-" : "."};
                end else begin
                    code = codes[$urandom_range(35, 0)];
                end
                send_code(w, (w == 0) ? 1 : 4, code, (n == 39) || ($urandom_range(3, 0) == 0));
            end
            drive_run(w, 1'b0, 30);
        end

        check_eq("drain_q0", q0.size(), 32'd0);
        check_eq("drain_q1", q1.size(), 32'd0);
        check_eq("char_hold0", {24'b0, char0}, 32'h20);
        check_eq("char_hold1", {24'b0, char1}, 32'h20);
        check_eq("idle_busy0", {31'b0, busy0}, 32'h0);
        check_eq("idle_busy1", {31'b0, busy1}, 32'h0);
`ifdef MORSE_RX_ERR_EN
        check_eq("err_cnt0", {24'b0, ecnt0}, exp_err0);
        check_eq("err_cnt1", {24'b0, ecnt1}, exp_err1);
`endif
        @(posedge clk);
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
